// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble)
// algorithm. One operand bit is consumed per clock; results that do not fit in
// DIGITS decimal digits saturate to all nines and raise overflow.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      ans,
    input  logic                  reqconversion,
    output logic                  busy,
    output logic                  conversiondone,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  negative,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_opnd;
    logic [BCD_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_sign;

    logic               w_start;
    logic               w_last;
    logic               w_neg_in;
    logic [WIDTH-1:0]   w_mag;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_acc_sh;
    logic [WIDTH-1:0]   w_opnd_sh;
    logic               w_shout;

    // Add 3 to every digit that is 5 or more; digits are independent, no carry.
    function automatic logic [BCD_W-1:0] f_add3(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    // Saturated result: every digit 9.
    function automatic logic [BCD_W-1:0] f_sat(input logic ovf, input logic [BCD_W-1:0] acc);
        return ovf ? {DIGITS{4'h9}} : acc;
    endfunction

    // Magnitude of the input; the most negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] f_mag(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + ONE) : v;
    endfunction

    assign w_neg_in  = (SIGNED != 0) && ans[WIDTH-1];
    assign w_mag     = f_mag(w_neg_in, ans);
    assign w_start   = ((r_state == IDLE) || (r_state == DONE)) && reqconversion;
    assign w_last    = (r_cnt == CNT_W'(1));

    assign w_adj     = f_add3(r_acc);
    assign w_shout   = w_adj[BCD_W-1];
    assign w_acc_sh  = {w_adj[BCD_W-2:0], r_opnd[WIDTH-1]};
    assign w_opnd_sh = {r_opnd[WIDTH-2:0], 1'b0};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; a request in DONE chains straight into a new conversion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = reqconversion ? SHIFT : IDLE;
            SHIFT:   w_next = w_last ? DONE : SHIFT;
            DONE:    w_next = reqconversion ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Working registers: capture the operand on start, then shift one bit per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opnd <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_sign <= 1'b0;
        end else if (w_start) begin
            r_opnd <= w_mag;
            r_sign <= w_neg_in;
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_cnt  <= CNT_W'(WIDTH);
        end else if (r_state == SHIFT) begin
            r_acc  <= w_acc_sh;
            r_opnd <= w_opnd_sh;
            r_ovf  <= r_ovf | w_shout;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // Registered outputs; results update only when leaving DONE and hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy           <= 1'b0;
            conversiondone <= 1'b0;
            bcd            <= '0;
            negative       <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            busy           <= (w_next != IDLE);
            conversiondone <= (r_state == DONE);
            if (r_state == DONE) begin
                bcd      <= f_sat(r_ovf, r_acc);
                negative <= r_sign;
                overflow <= r_ovf;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: default unsigned 20-bit/6-digit instance,
// a signed 8-bit/3-digit instance and a 4-bit/1-digit instance.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: WIDTH=20, DIGITS=6, unsigned
    logic [19:0] ansA = '0;
    logic        reqA = 1'b0;
    logic        busyA, doneA, negA, ovfA;
    logic [23:0] bcdA;

    // Instance B: WIDTH=8, DIGITS=3, signed
    logic [7:0]  ansB = '0;
    logic        reqB = 1'b0;
    logic        busyB, doneB, negB, ovfB;
    logic [11:0] bcdB;

    // Instance C: WIDTH=4, DIGITS=1, unsigned
    logic [3:0]  ansC = '0;
    logic        reqC = 1'b0;
    logic        busyC, doneC, negC, ovfC;
    logic [3:0]  bcdC;

    bin_to_bcd_seq #(.WIDTH(20), .DIGITS(6), .SIGNED(0)) u_a (
        .clk(clk), .rst(rst), .ans(ansA), .reqconversion(reqA), .busy(busyA),
        .conversiondone(doneA), .bcd(bcdA), .negative(negA), .overflow(ovfA));

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_b (
        .clk(clk), .rst(rst), .ans(ansB), .reqconversion(reqB), .busy(busyB),
        .conversiondone(doneB), .bcd(bcdB), .negative(negB), .overflow(ovfB));

    bin_to_bcd_seq #(.WIDTH(4), .DIGITS(1), .SIGNED(0)) u_c (
        .clk(clk), .rst(rst), .ans(ansC), .reqconversion(reqC), .busy(busyC),
        .conversiondone(doneC), .bcd(bcdC), .negative(negC), .overflow(ovfC));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-pulse request on A; returns ticks from the sampling edge to the done pulse
    // and the number of observed busy cycles.
    task automatic convA(input logic [19:0] v, output int lat, output int bcyc);
        ansA = v; reqA = 1'b1;
        tick();
        reqA = 1'b0;
        lat = 0;
        bcyc = busyA ? 1 : 0;
        while (!doneA && lat < 60) begin
            tick();
            lat++;
            if (busyA) bcyc++;
        end
        if (!doneA) chk("A_timeout", 64'(0), 64'(1));
    endtask

    task automatic convB(input logic [7:0] v, output int lat);
        ansB = v; reqB = 1'b1;
        tick();
        reqB = 1'b0;
        lat = 0;
        while (!doneB && lat < 30) begin tick(); lat++; end
        if (!doneB) chk("B_timeout", 64'(0), 64'(1));
    endtask

    task automatic convC(input logic [3:0] v);
        int lat;
        ansC = v; reqC = 1'b1;
        tick();
        reqC = 1'b0;
        lat = 0;
        while (!doneC && lat < 20) begin tick(); lat++; end
        if (!doneC) chk("C_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int lat, bcyc, seen, k;
        int dcy[3];
        logic [23:0] dval[3];

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busyA), 64'(0));
        chk("rst_done", 64'(doneA), 64'(0));
        chk("rst_bcd",  64'(bcdA),  64'(0));
        chk("rst_neg",  64'(negA),  64'(0));
        chk("rst_ovf",  64'(ovfA),  64'(0));

        // Largest in-range value: 21-cycle latency, 21 busy cycles
        convA(20'd999999, lat, bcyc);
        chk("a999_lat",  64'(lat),  64'(21));
        chk("a999_busy", 64'(bcyc), 64'(21));
        chk("a999_bcd",  64'(bcdA), 64'h999999);
        chk("a999_ovf",  64'(ovfA), 64'(0));
        chk("a999_neg",  64'(negA), 64'(0));
        tick();
        chk("a999_pulse", 64'(doneA), 64'(0));

        // Out-of-range value saturates, then a normal value clears overflow
        convA(20'hFFFFF, lat, bcyc);
        chk("aFFF_bcd", 64'(bcdA), 64'h999999);
        chk("aFFF_ovf", 64'(ovfA), 64'(1));
        convA(20'd123456, lat, bcyc);
        chk("a123_bcd", 64'(bcdA), 64'h123456);
        chk("a123_ovf", 64'(ovfA), 64'(0));
        repeat (5) tick();
        chk("hold_bcd",  64'(bcdA),  64'h123456);
        chk("hold_done", 64'(doneA), 64'(0));
        chk("idle_busy", 64'(busyA), 64'(0));

        // Reset in the middle of a conversion aborts it
        ansA = 20'd54321; reqA = 1'b1;
        tick();
        reqA = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_bcd",  64'(bcdA),  64'(0));
        chk("abort_busy", 64'(busyA), 64'(0));
        chk("abort_ovf",  64'(ovfA),  64'(0));
        seen = 0;
        repeat (30) begin tick(); if (doneA) seen++; end
        chk("abort_nodone", 64'(seen), 64'(0));

        // Request coinciding with reset is dropped
        rst = 1'b1; reqA = 1'b1; ansA = 20'd5;
        tick();
        rst = 1'b0; reqA = 1'b0;
        tick();
        chk("rstreq_busy", 64'(busyA), 64'(0));

        convA(20'd54321, lat, bcyc);
        chk("a543_bcd", 64'(bcdA), 64'h054321);

        // Continuous request: back-to-back results every 21 cycles, mid-shift ans changes ignored
        k = 0;
        ansA = 20'd1; reqA = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (doneA && k < 3) begin
                dcy[k] = c; dval[k] = bcdA; k++;
            end
            case (c)
                3:  ansA = 20'd5;
                10: ansA = 20'd2;
                25: ansA = 20'd9;
                30: ansA = 20'd3;
                45: ansA = 20'h77;
                50: reqA = 1'b0;
                default: ;
            endcase
        end
        chk("b2b_count", 64'(k), 64'(3));
        if (k == 3) begin
            chk("b2b_t0", 64'(dcy[0]), 64'(22));
            chk("b2b_t1", 64'(dcy[1]), 64'(43));
            chk("b2b_t2", 64'(dcy[2]), 64'(64));
            chk("b2b_v0", 64'(dval[0]), 64'h000001);
            chk("b2b_v1", 64'(dval[1]), 64'h000002);
            chk("b2b_v2", 64'(dval[2]), 64'h000003);
        end

        // Signed 8-bit, 3 digits
        convB(8'h80, lat);
        chk("s80_lat", 64'(lat),  64'(9));
        chk("s80_bcd", 64'(bcdB), 64'h128);
        chk("s80_neg", 64'(negB), 64'(1));
        chk("s80_ovf", 64'(ovfB), 64'(0));
        convB(8'h7F, lat);
        chk("s7F_bcd", 64'(bcdB), 64'h127);
        chk("s7F_neg", 64'(negB), 64'(0));
        convB(8'hFF, lat);
        chk("sFF_bcd", 64'(bcdB), 64'h001);
        chk("sFF_neg", 64'(negB), 64'(1));
        convB(8'h00, lat);
        chk("s00_bcd", 64'(bcdB), 64'h000);
        chk("s00_neg", 64'(negB), 64'(0));
        chk("s00_ovf", 64'(ovfB), 64'(0));

        // Single digit boundary
        convC(4'd9);
        chk("c9_bcd", 64'(bcdC), 64'h9);
        chk("c9_ovf", 64'(ovfC), 64'(0));
        convC(4'd10);
        chk("c10_bcd", 64'(bcdC), 64'h9);
        chk("c10_ovf", 64'(ovfC), 64'(1));
        chk("c10_neg", 64'(negC), 64'(0));
        convC(4'd0);
        chk("c0_bcd", 64'(bcdC), 64'h0);
        chk("c0_ovf", 64'(ovfC), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
